// File: rtl/ads886x_sample_avg.sv
// ads886x_sample_avg
// Block-averaging decimator for the ADS886x capture stream. Collects
// non-overlapping windows of 2**LOG2N signed samples and presents the
// window mean, minimum and maximum through a single valid/ready output
// register. A sticky flag records windows dropped because the consumer
// still held the previous result.
module ads886x_sample_avg #(
  parameter int LOG2N = 4,
  parameter int BITS  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [BITS-1:0] in_data,
  input  logic                   in_valid,
  input  logic                   clear,
  output logic signed [BITS-1:0] out_avg,
  output logic signed [BITS-1:0] out_min,
  output logic signed [BITS-1:0] out_max,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overrun,
  output logic [LOG2N-1:0]       win_cnt
);

  // The sum of N samples needs LOG2N growth bits, so it cannot overflow.
  localparam int              ACC_W    = BITS + LOG2N;
  localparam logic [LOG2N-1:0] CNT_LAST = '1;

  // Output register states
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Window accumulation state
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [LOG2N-1:0]        cnt_q, cnt_d;
  logic signed [BITS-1:0]  min_q, min_d;
  logic signed [BITS-1:0]  max_q, max_d;

  // Output register state
  logic [0:0]              state_q, state_d;
  logic signed [BITS-1:0]  avg_q, avg_d;
  logic signed [BITS-1:0]  omin_q, omin_d;
  logic signed [BITS-1:0]  omax_q, omax_d;
  logic                    ovr_q, ovr_d;

  // Per-cycle decode
  logic                    accept;
  logic                    complete;
  logic                    transfer;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [BITS-1:0]  samp_min;
  logic signed [BITS-1:0]  samp_max;

  // Next-state logic for the window trackers and the output register
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it
    // unassigned, which would otherwise infer a latch.
    accept   = in_valid & ~clear;
    complete = accept && (cnt_q == CNT_LAST);
    transfer = (state_q == ST_FULL) && out_ready;
    acc_sum  = acc_q + {{LOG2N{in_data[BITS-1]}}, in_data};
    // The first sample of a window loads both trackers unconditionally.
    samp_min = ((cnt_q == '0) || (in_data < min_q)) ? in_data : min_q;
    samp_max = ((cnt_q == '0) || (in_data > max_q)) ? in_data : max_q;

    acc_d   = acc_q;
    cnt_d   = cnt_q;
    min_d   = min_q;
    max_d   = max_q;
    state_d = state_q;
    avg_d   = avg_q;
    omin_d  = omin_q;
    omax_d  = omax_q;
    ovr_d   = ovr_q;

    if (clear) begin
      // Abort: drop the partial window, the pending result and the flag,
      // but leave the last presented values on the data outputs.
      acc_d   = '0;
      cnt_d   = '0;
      min_d   = '0;
      max_d   = '0;
      state_d = ST_EMPTY;
      ovr_d   = 1'b0;
    end else begin
      if (accept) begin
        if (complete) begin
          // Restart on the completing edge so the next sample opens a
          // fresh window with no bubble, whatever the output side does.
          acc_d = '0;
          cnt_d = '0;
          min_d = '0;
          max_d = '0;
        end else begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
          min_d = samp_min;
          max_d = samp_max;
        end
      end

      case (state_q)
        ST_EMPTY: begin
          if (complete) begin
            // Upper slice of the sum is the arithmetic shift by LOG2N,
            // i.e. the mean rounded toward minus infinity.
            avg_d   = acc_sum[ACC_W-1:LOG2N];
            omin_d  = samp_min;
            omax_d  = samp_max;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (complete && transfer) begin
            // Held result leaves on this edge, so the new one takes its slot.
            avg_d  = acc_sum[ACC_W-1:LOG2N];
            omin_d = samp_min;
            omax_d = samp_max;
          end else if (complete) begin
            // Consumer still holds the old result: drop the new window.
            ovr_d = 1'b1;
          end else if (transfer) begin
            state_d = ST_EMPTY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      state_q <= ST_EMPTY;
      avg_q   <= '0;
      omin_q  <= '0;
      omax_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      min_q   <= min_d;
      max_q   <= max_d;
      state_q <= state_d;
      avg_q   <= avg_d;
      omin_q  <= omin_d;
      omax_q  <= omax_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_avg   = avg_q;
  assign out_min   = omin_q;
  assign out_max   = omax_q;
  assign out_valid = (state_q == ST_FULL);
  assign overrun   = ovr_q;
  assign win_cnt   = cnt_q;

endmodule

// File: doc/ads886x_sample_avg.md
# ads886x_sample_avg

Block-averaging decimator directly downstream of the ADS886x serial capture stage. It consumes each signed 16-bit conversion result with its one-cycle valid strobe, forms non-overlapping windows of 2^LOG2N samples, and emits per window the arithmetic mean, minimum and maximum through a valid/ready output register. It also keeps a sticky overrun flag for windows lost to back-pressure.

## Interface
- LOG2N, 4, log2 of the window length N (N = 16 by default); legal range 1..8
- BITS, 16, sample width; samples are signed two's complement
- clk  in  1  system clock (66 MHz, same domain as the capture stage)
- rst  in  1  reset, synchronous, active-low (asserted when 0)
- in_data  in  BITS  signed sample; connect to the capture stage's data output
- in_valid  in  1  one-cycle sample strobe; connect to the capture stage's OutEn
- clear  in  1  synchronous abort: discard partial window, pending result and overrun
- out_avg  out  BITS  signed window mean
- out_min  out  BITS  signed window minimum
- out_max  out  BITS  signed window maximum
- out_valid  out  1  result register holds an untransferred result
- out_ready  in  1  consumer accepts the result
- overrun  out  1  sticky: a completed window was dropped
- win_cnt  out  LOG2N  samples accepted in the current window

## Operation
- Accumulator: signed, BITS+LOG2N bits; every accepted sample is sign-extended and added; no overflow is possible.
- Sample acceptance: in_valid=1 and clear=0. Back-to-back in_valid on consecutive cycles is fully supported; there is no input stall.
- Running min/max: the first sample of a window (win_cnt=0) loads both; later samples update with signed compares.
- Window completion: an accepted sample with win_cnt=N-1.
  - Result: avg = (acc + sample) >>> LOG2N, arithmetic shift, floor toward −inf. min/max include that sample.
  - The accumulator, win_cnt and min/max trackers restart from empty on the same edge, independent of the output state.
- Output register FSM:
  - EMPTY (out_valid=0): on completion → load result, go to FULL.
  - FULL (out_valid=1): out_avg, out_min and out_max stay stable until transfer (out_valid & out_ready).
  - FULL, transfer without completion → EMPTY.
  - FULL, transfer and completion in the same cycle → load the new result, stay FULL, no overrun.
  - FULL, completion without transfer → new result discarded, held result unchanged, overrun←1.
- overrun clears only on clear=1 or reset.
- clear=1 (priority over in_valid and out_ready):
  - acc, win_cnt, min/max trackers ← 0; out_valid ← 0; overrun ← 0; a sample presented the same cycle is dropped.
  - out_avg, out_min and out_max keep their last values.
- Reset (rst=0), including mid-window or with a result pending:
  - out_avg = out_min = out_max = 0; out_valid = 0; overrun = 0; win_cnt = 0; accumulator 0.
  - Inputs are ignored while rst=0.

## Timing
- All state updates on posedge clk; outputs are registered; no combinational path from inputs to outputs.
- Latency: out_valid rises on the clock edge that samples the N-th accepted in_valid, so it is visible the following cycle with the result valid.
- win_cnt increments on the edge that accepts a sample and wraps N-1 → 0 at completion.
- Throughput: one window per N accepted samples; zero bubble between windows.
- out_ready is sampled only while out_valid=1; with out_ready held high, each result is visible for exactly one cycle.
- In normal use (capture stage delivering one sample per ≥64 cycles, consumer always ready), overrun never sets.

## Test plan
- 16 × in_data=100, out_ready=1 → one result: avg=100, min=100, max=100; out_valid high for exactly 1 cycle; win_cnt back to 0.
- Ramp −8..+7, back-to-back in_valid → avg=−1 (sum −8, floor), min=−8, max=7; out_valid appears 1 cycle after the 16th strobe.
- Extremes: 16 × −32768 → avg=−32768; 16 × 32767 → avg=32767. No wrap; min/max equal the input.
- Back-pressure, out_ready=0:
  - Window A all 5, then window B all 9 → A's result held stable, overrun=1 on B's completion, B discarded.
  - Then out_ready=1 → A transfers, out_valid=0.
  - Then clear → overrun=0.
- Simultaneous: out_ready raised on the exact cycle window B (all 9) completes while A is held → A transferred, out_avg=9 next cycle, out_valid stays 1, overrun stays 0.
- 5 samples of 1000, then clear, then 16 × 10 → avg=10.
- Repeat with rst=0 instead of clear → all outputs 0 the cycle after reset, then avg=10.
